// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder block.
package fft_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reverses the low `width` bits of value; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[5'(i)] = value[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fft_reorder_ram #(
  parameter int ADDR_W = 11,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; bank state tracking guarantees no word is read before it is written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes frames at bit-reversed addresses and
// streams them out in natural order through a skid-buffered output stage.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int FFT_N  = 1024,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_re,
  input  logic [DATA_W-1:0]          in_im,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_re,
  output logic [DATA_W-1:0]          out_im,
  output logic [addr_w(FFT_N)-1:0]   out_index,
  output logic                       out_last
);

  localparam int AW = addr_w(FFT_N);
  localparam logic [AW-1:0] LAST = AW'(FFT_N - 1);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } sample_t;

  bank_state_t   bank_state [2];
  logic          wr_bank, rd_bank;
  logic [AW-1:0] wr_cnt, rd_cnt;
  logic          accept, out_xfer, rd_avail, rd_issue;
  logic          rd_pend;
  logic [AW-1:0] pend_idx;
  logic [1:0]    occ_after;
  sample_t       ram_q, skid;
  logic          skid_valid;
  logic [AW-1:0] skid_idx;
  logic [AW-1:0] wr_addr_lo;

  // NOTE: in_ready decodes registered bank state only, so no combinational path from out_ready or in_valid.
  assign in_ready = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING);
  assign accept   = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign rd_avail = (bank_state[rd_bank] == FULL) || (bank_state[rd_bank] == DRAINING);

  // Words held by the output stage once this edge settles; a new read is safe when at most one is held.
  assign occ_after  = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(out_xfer);
  assign rd_issue   = rd_avail && (occ_after <= 2'd1);
  assign wr_addr_lo = AW'(bitrev(32'(wr_cnt), AW));

  fft_reorder_ram #(
    .ADDR_W (AW + 1),
    .WIDTH  (2 * DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr ({wr_bank, wr_addr_lo}),
    .wr_data ({in_re, in_im}),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank, rd_cnt}),
    .rd_data (ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      rd_pend       <= 1'b0;
      pend_idx      <= '0;
    end else begin
      if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST) begin
          bank_state[wr_bank] <= FULL;
          wr_bank             <= ~wr_bank;
        end else if (bank_state[wr_bank] == EMPTY) begin
          bank_state[wr_bank] <= FILLING;
        end
      end
      rd_pend <= rd_issue;
      if (rd_issue) begin
        pend_idx <= rd_cnt;
        rd_cnt   <= rd_cnt + 1'b1;
        if (rd_cnt == '0) bank_state[rd_bank] <= DRAINING;
        if (rd_cnt == LAST) begin
          bank_state[rd_bank] <= EMPTY;
          rd_bank             <= ~rd_bank;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid       <= '0;
      skid_idx   <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_re     <= skid.re;
        out_im     <= skid.im;
        out_index  <= skid_idx;
        out_last   <= (skid_idx == LAST);
        skid_valid <= rd_pend;
        if (rd_pend) begin
          skid     <= ram_q;
          skid_idx <= pend_idx;
        end
      end else if (rd_pend) begin
        out_valid <= 1'b1;
        out_re    <= ram_q.re;
        out_im    <= ram_q.im;
        out_index <= pend_idx;
        out_last  <= (pend_idx == LAST);
      end else begin
        out_valid <= 1'b0;
      end
    end else if (rd_pend) begin
      // Output is stalled: park the arriving word in the skid register.
      skid_valid <= 1'b1;
      skid       <= ram_q;
      skid_idx   <= pend_idx;
    end
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side reader for the SDF radix-2 DIF pipeline. The last stage emits each frame in bit-reversed index order; this block buffers every frame and re-emits it in natural order (X[0]..X[FFT_N-1]).
- Ping-pong buffer: two banks of FFT_N complex words. Writes go to bit-reversed addresses; reads use a linear counter.
- Upstream stalls through in_ready, which drives the pipeline stage enables. Downstream uses a valid/ready handshake.

Parameters:
- FFT_N, 1024, frame length; power of two, >= 4.
- DATA_W, 16, signed width of each of re/im.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a sample from the last FFT stage is present.
- in_re  in  DATA_W  signed real part, bit-reversed order.
- in_im  in  DATA_W  signed imaginary part.
- in_ready  out  1  block can accept a sample this cycle; upstream enable.
- out_valid  out  1  out_* hold a valid natural-order sample.
- out_ready  in  1  downstream accepts the sample this cycle.
- out_re  out  DATA_W  signed real part, natural order.
- out_im  out  DATA_W  signed imaginary part.
- out_index  out  log2(FFT_N)  bin index k of out_re/out_im.
- out_last  out  1  high with k = FFT_N-1.

Behaviour:
- Frame boundaries are implicit: the first accepted sample after reset is element 0. Every FFT_N accepted samples close one frame.
- A sample is accepted when in_valid & in_ready. An output transfer happens when out_valid & out_ready.
- Reset values: in_ready=1, out_valid=0, out_last=0, out_index=0, out_re=out_im=0. wr_bank=rd_bank=0, both banks EMPTY, all counters 0.
- Per-bank state machine (2 bits each): EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY -> FILLING on the first write to the bank.
  - FILLING -> FULL on the write with wr_cnt = FFT_N-1. On the same edge, wr_bank toggles and wr_cnt wraps to 0.
  - FULL -> DRAINING when the reader issues read address 0.
  - DRAINING -> EMPTY on the edge that issues read address FFT_N-1. The data is then in the read pipeline, so the writer may overwrite the bank.
- Write path: on acceptance, write {in_re,in_im} to bank wr_bank at address bitrev(wr_cnt), then increment wr_cnt.
- in_ready = (state[wr_bank] is EMPTY or FILLING).
  - Decoded from registers only; there is no combinational path from out_ready or in_valid.
  - in_ready falls only when both banks are FULL/DRAINING and the write bank has not been released.
- Read path:
  - rd_cnt issues a synchronous RAM read (1-cycle latency) from bank rd_bank while that bank is FULL/DRAINING and the output stage has room.
  - rd_bank toggles after address FFT_N-1 is issued.
  - Output stage = output register plus a 1-entry skid register, so out_ready may drop at any cycle without loss or duplication.
  - Sustained throughput is 1 sample/cycle when out_ready is held high.
- Latency: last sample of a frame accepted at edge E (out_ready high) -> out_valid=1 with out_index=0 after edge E+2. Output then runs contiguously to out_last.
- Back-to-back frames with in_valid and out_ready held high: in_ready never drops; the output has no gaps between frames after the first.
- Holding: out_* are stable while out_valid & ~out_ready. out_valid never drops without a transfer.
- Simultaneous release and write (DRAINING -> EMPTY on the edge where the writer is blocked on that bank): in_ready rises on the next cycle. No write is lost; no stale data is overwritten.
- Reset mid-operation: all frames in flight are discarded, banks return to EMPTY, and the next accepted sample is element 0.
- No arithmetic on data: pass-through bit-exact, no saturation or rounding.

Decomposition:
- Shared package fft_pkg:
  - DATA_W default.
  - clog2-based ADDR_W function.
  - Parameterised bitrev(value, width) function.
  - Bank-state encoding constants EMPTY/FILLING/FULL/DRAINING.
- One sub-module fft_reorder_ram: simple dual-port RAM, 2*FFT_N x 2*DATA_W. One write port, one synchronous read port, address = {bank, index}.
- Control, counters and skid buffer stay in the top.

Test Plan (FFT_N=8 unless noted):
- After reset, feed values re=0..7 (im=-re) with in_valid high and out_ready high -> out_re sequence 0,4,2,6,1,5,3,7, im negated. out_index 0..7. out_last only with index 7. First out_valid 2 cycles after the 8th accept.
- Three back-to-back frames, in_valid and out_ready held high -> in_ready stays 1. The 24 outputs are contiguous and correct per frame.
- out_ready held 0 while feeding 3 frames -> in_ready falls after the 16th accept and frame 3's data is not written. Releasing out_ready delivers frames 1 and 2 intact, then in_ready rises.
- out_ready toggled pseudo-randomly (50%) over 4 frames -> no sample lost or duplicated, out_* stable whenever out_valid & ~out_ready.
- Assert rst after 5 samples of a frame and after 3 outputs of another -> outputs go to reset values immediately. The next 8 inputs form a clean frame with correct reorder.
- FFT_N=1024, one frame with re=n -> out_re[k] = bitrev10(k) for all k.
